// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// No logic: state encoding, line idle level and counter sizing only.
// No flow control here; consumers qualify everything with the bit strobe.
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_PARITY    = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Counter must hold the value DATA_W itself, hence +1.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_frame_rx_shift_reg.sv
// Right-shifting capture register: new bit enters at the MSB, so LSB-first line order lands in place.
// Latency: one clk per enabled shift; synchronous clear wins over shift.
// No backpressure: shifts whenever enabled.
module rx_shift_reg
    import serial_frame_rx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {i_d, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial word receiver (start, DATA_W LSB-first, optional parity, stop), sampled on bit_en strobes.
// Latency: valid/parity_err/frame_err registered on the stop-bit sample edge, one clk wide.
// No backpressure: each completed word overwrites data_out.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bit_en,
    input  logic              i_s_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int             CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic           PAR_ON   = (PARITY_EN != 0);
    localparam logic           ODD_BIT  = (PARITY_ODD != 0);

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic              r_par_bit;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic [DATA_W-1:0] w_shift_q;
    logic              w_shift_clr;
    logic              w_shift_en;
    logic              w_par_mismatch;

    assign w_shift_clr    = i_bit_en && (r_state == ST_IDLE);
    assign w_shift_en     = i_bit_en && (r_state == ST_DATA);
    assign w_par_mismatch = PAR_ON & (r_par ^ r_par_bit ^ ODD_BIT);

    rx_shift_reg #(
        .W (DATA_W)
    ) u_shift (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_shift_clr),
        .i_en    (w_shift_en),
        .i_d     (i_s_in),
        .o_q     (w_shift_q)
    );

    always_comb begin
        w_next = r_state;
        if (i_bit_en) begin
            case (r_state)
                ST_IDLE:      if (i_s_in != LINE_IDLE) w_next = ST_DATA;
                ST_DATA:      if (r_cnt == LAST_IDX) w_next = PAR_ON ? ST_PARITY : ST_STOP;
                ST_PARITY:    w_next = ST_STOP;
                // A low stop bit parks the FSM until the line returns high,
                // so a stuck-low line cannot spawn back-to-back bogus frames.
                ST_STOP:      w_next = (i_s_in == LINE_IDLE) ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (i_s_in == LINE_IDLE) w_next = ST_IDLE;
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_par        <= 1'b0;
            r_par_bit    <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            if (i_bit_en) begin
                r_state <= w_next;
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                        r_par <= 1'b0;
                    end
                    ST_DATA: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_par <= r_par ^ i_s_in;
                    end
                    ST_PARITY: r_par_bit <= i_s_in;
                    ST_STOP: begin
                        if (i_s_in == LINE_IDLE) begin
                            r_data_out   <= w_shift_q;
                            r_data_valid <= 1'b1;
                            r_parity_err <= w_par_mismatch;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus randomized frames against a frame-level model.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    logic reset;
    logic bit_en_a, s_in_a, bit_en_b, s_in_b;
    logic [7:0] data_out_a, data_out_b;
    logic dv_a, pe_a, fe_a, busy_a;
    logic dv_b, pe_b, fe_b, busy_b;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_a (
        .i_clk(clk), .i_reset(reset), .i_bit_en(bit_en_a), .i_s_in(s_in_a),
        .o_data_out(data_out_a), .o_data_valid(dv_a), .o_parity_err(pe_a),
        .o_frame_err(fe_a), .o_busy(busy_a)
    );

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_bit_en(bit_en_b), .i_s_in(s_in_b),
        .o_data_out(data_out_b), .o_data_valid(dv_b), .o_parity_err(pe_b),
        .o_frame_err(fe_b), .o_busy(busy_b)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        int         cyc;
    } ev_t;

    ev_t  q_a[$];
    ev_t  q_b[$];
    int   fe_cnt_a = 0, fe_cnt_b = 0;
    int   long_a = 0, long_b = 0;
    logic prev_dv_a = 1'b0, prev_dv_b = 1'b0, prev_fe_a = 1'b0, prev_fe_b = 1'b0;
    int   cyc = 0;
    int   n_pass = 0, n_chk = 0;
    logic [7:0] last_good_a = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe pulses on the opposite edge; any pulse wider than one cycle is logged.
    always @(negedge clk) begin
        if (dv_a) q_a.push_back('{d: data_out_a, pe: pe_a, cyc: cyc});
        if (dv_b) q_b.push_back('{d: data_out_b, pe: pe_b, cyc: cyc});
        if (fe_a) fe_cnt_a++;
        if (fe_b) fe_cnt_b++;
        if ((dv_a && prev_dv_a) || (fe_a && prev_fe_a)) long_a++;
        if ((dv_b && prev_dv_b) || (fe_b && prev_fe_b)) long_b++;
        prev_dv_a = dv_a; prev_fe_a = fe_a;
        prev_dv_b = dv_b; prev_fe_b = fe_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic put_bit(input bit sel, input logic b, input int gap);
        if (sel) begin s_in_b = b; bit_en_b = 1'b1; end
        else     begin s_in_a = b; bit_en_a = 1'b1; end
        @(negedge clk);
        bit_en_a = 1'b0;
        bit_en_b = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Frame-level model: the word either arrives with parity judged by bit count,
    // or (low stop bit) nothing arrives and one frame error is seen.
    task automatic send_frame(input bit sel, input logic [7:0] word, input logic pflip,
                              input logic stop, input int gap, input string tag);
        int   nq, nfe;
        logic pbit, exp_pe;
        ev_t  e;
        nq   = sel ? q_b.size() : q_a.size();
        nfe  = sel ? fe_cnt_b : fe_cnt_a;
        pbit = logic'(($countones(word) % 2) != 0) ^ pflip;
        exp_pe = sel ? 1'b0 : logic'((($countones(word) + int'(pbit)) % 2) != 0);
        put_bit(sel, 1'b0, gap);
        for (int i = 0; i < 8; i++) put_bit(sel, word[i], gap);
        if (!sel) put_bit(sel, pbit, gap);
        put_bit(sel, stop, gap);
        #1;
        if (stop) begin
            chk({tag, "_count"}, sel ? q_b.size() : q_a.size(), nq + 1);
            if ((sel ? q_b.size() : q_a.size()) > nq) begin
                e = sel ? q_b[$] : q_a[$];
                chk({tag, "_data"}, e.d, word);
                chk({tag, "_perr"}, e.pe, exp_pe);
            end
            chk({tag, "_held"}, sel ? data_out_b : data_out_a, word);
            chk({tag, "_idle"}, sel ? busy_b : busy_a, 0);
            if (!sel) last_good_a = word;
        end else begin
            chk({tag, "_nodv"}, sel ? q_b.size() : q_a.size(), nq);
            chk({tag, "_ferr"}, sel ? fe_cnt_b : fe_cnt_a, nfe + 1);
            if (!sel) chk({tag, "_keep"}, data_out_a, last_good_a);
            chk({tag, "_busy"}, sel ? busy_b : busy_a, 1);
        end
    endtask

    initial begin
        int n0, c0, k, g;
        logic [7:0] w;
        reset = 1'b1; bit_en_a = 1'b0; bit_en_b = 1'b0; s_in_a = 1'b1; s_in_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", data_out_a, 0);
        chk("rst_dv",   dv_a, 0);
        chk("rst_pe",   pe_a, 0);
        chk("rst_fe",   fe_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        reset = 1'b0;
        @(negedge clk);

        // Idle-high strobes must not start a frame.
        repeat (3) put_bit(0, 1'b1, 2);
        chk("idle_busy", busy_a, 0);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 4, "a5_even");
        send_frame(0, 8'hA5, 1'b1, 1'b1, 4, "a5_flip");

        // Start-then-busy timing: busy appears the cycle after the start sample.
        put_bit(0, 1'b0, 1);
        chk("busy_rise", busy_a, 1);
        for (int i = 0; i < 8; i++) put_bit(0, 1'b1, 1);
        put_bit(0, 1'b0, 1);
        put_bit(0, 1'b1, 1);
        #1;
        chk("ff_data", data_out_a, 8'hFF);
        last_good_a = 8'hFF;

        // Low stop bit, then a stuck-low line.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 4, "3c_stop0");
        n0 = q_a.size(); c0 = fe_cnt_a;
        repeat (5) put_bit(0, 1'b0, 4);
        #1;
        chk("stuck_nodv", q_a.size(), n0);
        chk("stuck_nofe", fe_cnt_a, c0);
        chk("stuck_busy", busy_a, 1);
        put_bit(0, 1'b1, 4);
        #1;
        chk("stuck_exit", busy_a, 0);

        // Reset during data bit 4 discards the partial word.
        put_bit(0, 1'b0, 4);
        for (int i = 0; i < 4; i++) put_bit(0, 1'b1, 4);
        s_in_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        s_in_a = 1'b1;
        chk("mid_rst_data", data_out_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_dv", dv_a, 0);
        last_good_a = 8'h00;
        send_frame(0, 8'h0F, 1'b0, 1'b1, 4, "0f_after_rst");

        // No-parity instance, back-to-back frames.
        n0 = q_b.size();
        send_frame(1, 8'hFF, 1'b0, 1'b1, 2, "b2b_ff");
        send_frame(1, 8'h00, 1'b0, 1'b1, 2, "b2b_00");
        if (q_b.size() >= n0 + 2)
            chk("b2b_spacing", q_b[n0 + 1].cyc - q_b[n0].cyc, 20);
        else
            chk("b2b_spacing_missing", q_b.size(), n0 + 2);

        // Randomized frames on the parity instance.
        for (int r = 0; r < 14; r++) begin
            w = 8'($urandom_range(0, 255));
            g = $urandom_range(1, 4);
            send_frame(0, w, logic'($urandom_range(0, 3) == 0),
                       logic'($urandom_range(0, 4) != 0), g, $sformatf("rnd%0d", r));
            if (busy_a) begin
                k = $urandom_range(0, 3);
                repeat (k) put_bit(0, 1'b0, g);
                put_bit(0, 1'b1, g);
                #1;
                chk($sformatf("rnd%0d_recover", r), busy_a, 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("pulse_width_a", long_a, 0);
        chk("pulse_width_b", long_b, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
